// File: rtl/ex_muldiv_pkg.sv
// Shared M-extension decode constants, FSM state type and sign helper for ex_muldiv.
package ex_muldiv_pkg;

  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam logic [6:0]  INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0]  INST_FUNCT7_M = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } md_state_e;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, 32 cycles after start.
// done_o is high during the final step cycle; results are valid from the following cycle.
module div_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    // Partial remainder is always < divisor, so the shifted value fits in 33 bits.
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = 5'd0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = 5'd0;
      quo_d  = dividend_i;
      rem_d  = 32'd0;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      cnt_d = cnt_q + 5'd1;
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      if (cnt_q == 5'd31) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= 5'd0;
      quo_q  <= 32'd0;
      rem_q  <= 32'd0;
      dvs_q  <= 32'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == 5'd31);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execute unit: 34-cycle divide/remainder via div_core, 2 cycles for div-by-zero/overflow.
// Define EX_MULDIV_MUL_EN to add single-cycle MUL/MULH/MULHSU/MULHU; otherwise they are not decoded.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        jump_en_i,
  output logic        md_op_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_we_o,
  output logic        hold_flag_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       is_m, is_div, is_mul;
  logic       op_signed, div_zero, div_ovf;
  logic       unused_ins;

  assign opcode     = ins_i[6:0];
  assign rd         = ins_i[11:7];
  assign funct3     = ins_i[14:12];
  assign funct7     = ins_i[31:25];
  assign unused_ins = ^ins_i[24:15];

  assign is_m   = (opcode == INST_TYPE_R_M) && (funct7 == INST_FUNCT7_M);
  assign is_div = is_m && funct3[2];
`ifdef EX_MULDIV_MUL_EN
  assign is_mul = is_m && !funct3[2];
`else
  assign is_mul = 1'b0;
`endif
  assign md_op_o = is_div || is_mul;

  assign op_signed = !funct3[0];
  assign div_zero  = (rs2_data_i == 32'd0);
  assign div_ovf   = op_signed && (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);

`ifdef EX_MULDIV_MUL_EN
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_p;
  logic [31:0]        mul_res;
  always_comb begin
    mul_a   = $signed({(funct3 != INST_MULHU) && rs1_data_i[31], rs1_data_i});
    mul_b   = $signed({(funct3 == INST_MULH) && rs2_data_i[31], rs2_data_i});
    mul_p   = mul_a * mul_b;
    mul_res = (funct3 == INST_MUL) ? mul_p[31:0] : mul_p[63:32];
  end
`endif

  md_state_e   state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        special_q, special_d;
  logic [31:0] res_q, res_d;

  logic        div_start, div_busy, div_done;
  logic [31:0] div_quo, div_rem;
  logic [31:0] div_res, done_data;
  logic        unused_busy;

  div_core u_div_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .abort_i     (jump_en_i),
    .dividend_i  (neg_if(rs1_data_i, op_signed && rs1_data_i[31])),
    .divisor_i   (neg_if(rs2_data_i, op_signed && rs2_data_i[31])),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );
  assign unused_busy = div_busy;

  assign div_res   = funct3_q[1] ? neg_if(div_rem, negr_q) : neg_if(div_quo, negq_q);
  assign done_data = special_q ? res_q : div_res;

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    special_d   = special_q;
    res_d       = res_q;
    div_start   = 1'b0;
    hold_flag_o = 1'b0;
    rd_we_o     = 1'b0;
    rd_data_o   = 32'd0;
    rd_addr_o   = 5'd0;
    case (state_q)
      ST_IDLE: begin
        if (is_div && !jump_en_i) begin
          hold_flag_o = 1'b1;
          funct3_d    = funct3;
          rd_d        = rd;
          negq_d      = op_signed && (rs1_data_i[31] ^ rs2_data_i[31]);
          negr_d      = op_signed && rs1_data_i[31];
          // Special cases bypass the divider and write back from res_q.
          if (div_zero) begin
            special_d = 1'b1;
            res_d     = funct3[1] ? rs1_data_i : 32'hFFFF_FFFF;
            state_d   = ST_DONE;
          end else if (div_ovf) begin
            special_d = 1'b1;
            res_d     = funct3[1] ? 32'd0 : 32'h8000_0000;
            state_d   = ST_DONE;
          end else begin
            special_d = 1'b0;
            div_start = 1'b1;
            state_d   = ST_BUSY;
          end
        end
`ifdef EX_MULDIV_MUL_EN
        else if (is_mul && !jump_en_i) begin
          rd_we_o   = 1'b1;
          rd_data_o = mul_res;
          rd_addr_o = rd;
        end
`endif
      end
      ST_BUSY: begin
        hold_flag_o = !jump_en_i;
        if (div_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!jump_en_i) begin
          rd_we_o   = 1'b1;
          rd_data_o = done_data;
          rd_addr_o = rd_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (jump_en_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      funct3_q  <= 3'd0;
      rd_q      <= 5'd0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      special_q <= 1'b0;
      res_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      special_q <= special_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus randomized divides against an arithmetic model.
module tb_ex_muldiv;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins_i, rs1_data_i, rs2_data_i;
  logic        jump_en_i;
  logic        md_op_o, rd_we_o, hold_flag_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .ins_i       (ins_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .jump_en_i   (jump_en_i),
    .md_op_o     (md_op_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_we_o     (rd_we_o),
    .hold_flag_o (hold_flag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Reference: plain 64-bit arithmetic; RISC-V M rules for division by zero.
  function automatic logic [31:0] div_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f3[0]) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int hold_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, stall while hold is high, then check the single writeback.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag,
                        input logic [31:0] exp_data, input int exp_hold);
    int  hold_cnt;
    bit  fin;
    @(posedge clk);
    #1;
    ins_i      = mk_ins(f3, rd);
    rs1_data_i = a;
    rs2_data_i = b;
    hold_cnt   = 0;
    fin        = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) check({tag, "_mdop"}, 32'(md_op_o), 32'd1);
      if (rd_we_o) begin
        fin = 1'b1;
        check({tag, "_data"}, rd_data_o, exp_data);
        check({tag, "_rd"}, 32'(rd_addr_o), 32'(rd));
        check({tag, "_hold"}, 32'(hold_cnt), 32'(exp_hold));
      end else if (hold_flag_o) begin
        hold_cnt++;
        if (c == 1) check({tag, "_quiet"}, rd_data_o, 32'd0);
      end else begin
        fin = 1'b1;
        check({tag, "_nowb"}, 32'(rd_we_o), 32'd1);
      end
    end
    if (!fin) check({tag, "_timeout"}, 32'(rd_we_o), 32'd1);
  endtask

  task automatic idle(input int n, input string tag);
    @(posedge clk);
    #1;
    ins_i = NOP;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_ctl"}, {25'd0, md_op_o, hold_flag_o, rd_we_o, rd_addr_o[3:0]}, 32'd0);
      check({tag, "_data"}, rd_data_o, 32'd0);
    end
  endtask

  // Start DIVU, then kill it with jump or reset in BUSY cycle 10.
  task automatic abort_test(input bit use_rst, input string tag);
    int wb_cnt;
    @(posedge clk);
    #1;
    ins_i      = mk_ins(3'b101, 5'd9);
    rs1_data_i = 32'd100;
    rs2_data_i = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else jump_en_i = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    jump_en_i = 1'b0;
    ins_i     = NOP;
    @(negedge clk);
    check({tag, "_hold"}, 32'(hold_flag_o), 32'd0);
    check({tag, "_we"}, 32'(rd_we_o), 32'd0);
    wb_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_we_o || hold_flag_o) wb_cnt++;
    end
    check({tag, "_nowb"}, 32'(wb_cnt), 32'd0);
  endtask

`ifdef EX_MULDIV_MUL_EN
  function automatic logic [31:0] mul_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [127:0] pa, pb, pr;
    pa = (f3 == 3'b011) ? $signed({96'd0, a}) : $signed({{96{a[31]}}, a});
    pb = (f3 == 3'b001) ? $signed({{96{b[31]}}, b}) : $signed({96'd0, b});
    pr = pa * pb;
    return (f3 == 3'b000) ? pr[31:0] : pr[63:32];
  endfunction
`endif

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    rst        = 1'b1;
    jump_en_i  = 1'b0;
    ins_i      = NOP;
    rs1_data_i = 32'd0;
    rs2_data_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", {26'd0, md_op_o, hold_flag_o, rd_we_o, 3'd0} | 32'(rd_addr_o), 32'd0);
    check("reset_data", rd_data_o, 32'd0);
    rst = 1'b0;
    idle(2, "idle0");

    run_op(3'b101, 32'd100, 32'd7, 5'd3, "divu_100_7", 32'd14, 33);
    run_op(3'b111, 32'd100, 32'd7, 5'd4, "remu_100_7", 32'd2, 33);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, "div_m7_2", 32'hFFFF_FFFD, 33);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_m7_2", 32'hFFFF_FFFF, 33);
    run_op(3'b100, 32'd5, 32'd0, 5'd7, "div_5_0", 32'hFFFF_FFFF, 1);
    run_op(3'b110, 32'd5, 32'd0, 5'd8, "rem_5_0", 32'd5, 1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, "div_ovf", 32'h8000_0000, 1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "rem_ovf", 32'd0, 1);
    idle(2, "idle1");

    abort_test(1'b0, "jump_abort");
    abort_test(1'b1, "rst_abort");
    run_op(3'b101, 32'hFFFF_FFFF, 32'd3, 5'd12, "divu_after_abort", 32'h5555_5555, 33);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(1, 31));
      run_op(f3, a, b, rd, $sformatf("rnd%0d", i), div_model(f3, a, b), hold_model(f3, a, b));
    end

`ifdef EX_MULDIV_MUL_EN
    run_op(3'b001, 32'h8000_0000, 32'd2, 5'd13, "mulh", 32'hFFFF_FFFF, 0);
    run_op(3'b011, 32'h8000_0000, 32'd2, 5'd14, "mulhu", 32'd1, 0);
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      run_op(f3, a, b, 5'd15, $sformatf("rmul%0d", i), mul_model(f3, a, b), 0);
    end
`else
    @(posedge clk);
    #1;
    ins_i      = mk_ins(3'b001, 5'd13);
    rs1_data_i = 32'h8000_0000;
    rs2_data_i = 32'd2;
    @(negedge clk);
    check("mul_off_mdop", 32'(md_op_o), 32'd0);
    check("mul_off_ctl", {30'd0, hold_flag_o, rd_we_o}, 32'd0);
`endif

    idle(3, "idle_end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
